alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised MIPS execute unit: ALU-control decode (aluop/func) plus datapath, with an iterative
//  multiply/divide engine and HI/LO registers. Sits between ID/EX regs and EX/MEM; valid/ready
//  handshake on both sides so multi-cycle ops stall the front end. One operation in flight at a time.
// PARAMETERS
//  WIDTH    32  datapath width (power of 2, >=8)
//  SHAMT_W  5   shift-amount width, = $clog2(WIDTH)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        op presented
//  in_ready   out  1        unit can accept (state IDLE)
//  aluop      in   3        000 R-type(use func),001 lw,010 sw,011 andi,110 beq; else illegal
//  func       in   6        R-type function field
//  shamt      in   SHAMT_W  shift amount for sll/srl
//  src_a      in   WIDTH    rs operand
//  src_b      in   WIDTH    rt / immediate operand
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        downstream accepts
//  result     out  WIDTH    result
//  zero       out  1        result==0 (beq)
//  illegal    out  1        undecodable aluop/func
//  div0       out  1        divide by zero occurred
//  hi, lo     out  WIDTH    architectural HI/LO
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; out_valid,result,zero,illegal,div0,hi,lo = 0; any op in flight
//   discarded, HI/LO not updated. in_ready=1 in the first cycle after reset release.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE); no accept while busy or output pending.
//  Decode: lw,sw->ADD; andi->AND; beq->SUB. func: 100000 ADD,100010 SUB,100100 AND,100101 OR,
//   100111 NOR,101010 SLT,000000 SLL,000010 SRL,010000 MFHI,010010 MFLO,011000 MULT,011001 MULTU,
//   011010 DIV,011011 DIVU; else illegal.
//  Single-cycle ops: IDLE->DONE; out_valid=1 the cycle after accept (latency 1).
//   ADD/SUB modulo 2^WIDTH, no overflow trap. SLT signed compare, result 0/1. SLL/SRL shift src_b
//   by shamt (SRL zero-fill). MFHI/MFLO return HI/LO as of accept.
//  Illegal: IDLE->DONE, latency 1, illegal=1, result=0, HI/LO untouched.
//  MULT/MULTU/DIV/DIVU: IDLE->ITER (WIDTH cycles, 1 bit/cycle) ->FIX (1 cycle) ->DONE;
//   out_valid asserts WIDTH+2 cycles after accept. Signed ops run on magnitudes, FIX applies sign:
//   product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
//   HI/LO written in FIX: mul HI:LO=product; div LO=quotient, HI=remainder. result=LO.
//  Divide by zero: no iteration (IDLE->FIX directly), LO=all ones, HI=src_a, div0=1.
//  Signed DIV of most-negative by -1: LO=most-negative, HI=0 (wrap, no trap).
//  DONE: outputs held stable while out_ready=0; on out_ready=1 -> IDLE, out_valid=0 next cycle.
//   Back-to-back single-cycle ops therefore sustain 1 op / 2 cycles.
//  zero, illegal, div0 valid only while out_valid=1; cleared on leaving DONE.
// STRUCTURE
//  alu_pkg: ALUOP_* and FUNC_* constants, ctrl-op enum (ADD..DIVU), FSM state encoding.
//  Sub-module alu_mdu_seq: iterative shift-add multiplier / restoring divider on unsigned
//   magnitudes, start/done handshake, WIDTH-cycle count; top keeps decode, 1-cycle ALU, FSM, sign fix, HI/LO.
// TESTING
//  1 ADD/SUB: aluop=000 func=100010 a=5 b=5 -> out_valid next cycle, result=0, zero=1.
//  2 MULT: a=-3 b=7 (WIDTH=32) -> out_valid at cycle 34, LO=0xFFFFFFEB, HI=0xFFFFFFFF; MFHI returns it.
//  3 DIV: a=-7 b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU a=7 b=0 -> div0=1, LO=0xFFFFFFFF, HI=7.
//  4 Backpressure: out_ready=0 for 5 cycles after SLT a=-1 b=1 -> result=1 held, in_ready=0 throughout.
//  5 Reset mid-MULTU at iteration 10 -> next cycle in_ready=1, hi=lo=0, no out_valid.
//  6 Illegal: aluop=111 or func=111111 -> illegal=1, result=0, HI/LO unchanged; SLL shamt=31 b=1 -> 0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute unit.
// Holds the aluop/func encodings, the decoded control-op enum, the FSM
// state enum and small helper functions used by the decode path.
package alu_pkg;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_LW    = 3'b001;
  localparam logic [2:0] ALUOP_SW    = 3'b010;
  localparam logic [2:0] ALUOP_ANDI  = 3'b011;
  localparam logic [2:0] ALUOP_BEQ   = 3'b110;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLL   = 6'b000000;
  localparam logic [5:0] FUNC_SRL   = 6'b000010;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL,
    OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } ctrl_op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_ITER, S_FIX, S_DONE
  } state_e;

  function automatic ctrl_op_e decode_op(input logic [2:0] aluop,
                                         input logic [5:0] func);
    ctrl_op_e op;
    op = OP_ILL;
    case (aluop)
      ALUOP_LW, ALUOP_SW: op = OP_ADD;
      ALUOP_ANDI:         op = OP_AND;
      ALUOP_BEQ:          op = OP_SUB;
      ALUOP_RTYPE: begin
        case (func)
          FUNC_ADD:   op = OP_ADD;
          FUNC_SUB:   op = OP_SUB;
          FUNC_AND:   op = OP_AND;
          FUNC_OR:    op = OP_OR;
          FUNC_NOR:   op = OP_NOR;
          FUNC_SLT:   op = OP_SLT;
          FUNC_SLL:   op = OP_SLL;
          FUNC_SRL:   op = OP_SRL;
          FUNC_MFHI:  op = OP_MFHI;
          FUNC_MFLO:  op = OP_MFLO;
          FUNC_MULT:  op = OP_MULT;
          FUNC_MULTU: op = OP_MULTU;
          FUNC_DIV:   op = OP_DIV;
          FUNC_DIVU:  op = OP_DIVU;
          default:    op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic logic is_mdu_op(input ctrl_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input ctrl_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_mdu_op(input ctrl_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu_seq.sv
// Iterative unsigned multiply / divide engine, one bit per cycle.
// Multiply: shift-add, {o_hi,o_lo} = i_a * i_b after WIDTH steps.
// Divide: restoring division, o_lo = i_a / i_b, o_hi = i_a % i_b.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   i_start     load operands and begin (ignored meaning while busy: restarts)
//   i_is_div    1 = divide, 0 = multiply
//   i_a, i_b    unsigned operands (multiplicand/dividend, multiplier/divisor)
//   o_last      high during the cycle whose edge performs the final step
//   o_hi, o_lo  working/result registers, final after the o_last edge
import alu_pkg::*;

module alu_mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_div;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  // Multiply: HI accumulates, LO holds the multiplier shifting out while
  // product bits shift in from the top. Divide: LO holds the dividend
  // shifting into the partial remainder and collects quotient bits.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'(WIDTH);
      r_busy <= 1'b1;
      r_div  <= i_is_div;
      r_b    <= i_b;
      r_hi   <= '0;
      r_lo   <= i_a;
    end else if (r_busy) begin
      if (r_div) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_rem_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
      end
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_last = r_busy && (r_cnt == CNT_W'(1));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS execute unit: aluop/func decode, single-cycle ALU, iterative
// multiply/divide with sign fix-up, and the architectural HI/LO registers.
// One operation in flight; valid/ready on both the issue and result side.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     issue handshake (ready only in IDLE)
//   aluop, func, shamt    control fields from ID/EX
//   src_a, src_b          rs and rt/immediate operands
//   out_valid/out_ready   result handshake, outputs held while stalled
//   result, zero          result and result==0
//   illegal, div0         undecodable op / divide by zero flags
//   hi, lo                architectural HI/LO
import alu_pkg::*;

module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         aluop,
  input  logic [5:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               div0,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e           r_state;
  state_e           w_next;

  ctrl_op_e         w_op;
  ctrl_op_e         r_op;
  logic             w_accept;
  logic             w_is_mdu;
  logic             w_signed;
  logic             w_dz;
  logic             w_mdu_start;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_alu_res;

  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_dz;
  logic [WIDTH-1:0] r_src_a;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_mdu_last;
  logic [WIDTH-1:0] w_mdu_hi;
  logic [WIDTH-1:0] w_mdu_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // ---------------- decode / operand prep ----------------
  always_comb begin
    w_op        = decode_op(aluop, func);
    w_accept    = in_valid && in_ready;
    w_is_mdu    = is_mdu_op(w_op);
    w_signed    = is_signed_mdu_op(w_op);
    w_dz        = is_div_op(w_op) && (src_b == '0);
    w_mdu_start = w_accept && w_is_mdu && !w_dz;
    // Most-negative maps to itself, which is the correct unsigned magnitude.
    w_mag_a     = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    w_mag_b     = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = src_a + src_b;
      OP_SUB:  w_alu_res = src_a - src_b;
      OP_AND:  w_alu_res = src_a & src_b;
      OP_OR:   w_alu_res = src_a | src_b;
      OP_NOR:  w_alu_res = ~(src_a | src_b);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLL:  w_alu_res = src_b << shamt;
      OP_SRL:  w_alu_res = src_b >> shamt;
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  // ---------------- iterative engine ----------------
  alu_mdu_seq #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mdu_start),
    .i_is_div (is_div_op(w_op)),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_last   (w_mdu_last),
    .o_hi     (w_mdu_hi),
    .o_lo     (w_mdu_lo)
  );

  // Sign fix-up applied to the magnitude results in FIX.
  always_comb begin
    w_prod   = {w_mdu_hi, w_mdu_lo};
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (is_div_op(r_op)) begin
      if (r_dz) begin
        w_fix_lo = '1;
        w_fix_hi = r_src_a;
      end else begin
        w_fix_lo = r_neg_lo ? -w_mdu_lo : w_mdu_lo;
        w_fix_hi = r_neg_hi ? -w_mdu_hi : w_mdu_hi;
      end
    end else begin
      if (r_neg_lo) begin
        w_prod = -w_prod;
      end
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_dz)          w_next = S_FIX;
          else if (w_is_mdu) w_next = S_ITER;
          else               w_next = S_DONE;
        end
      end
      // Leave on the edge that performs the final step, so FIX sees
      // settled magnitudes and ITER lasts exactly WIDTH cycles.
      S_ITER:  if (w_mdu_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_ADD;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_dz      <= 1'b0;
      r_src_a   <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= w_op;
            r_neg_lo <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_hi <= w_signed && src_a[WIDTH-1];
            r_dz     <= w_dz;
            r_src_a  <= src_a;
            if (!w_is_mdu) begin
              r_result  <= w_alu_res;
              r_zero    <= (w_alu_res == '0);
              r_illegal <= (w_op == OP_ILL);
            end
          end
        end
        S_FIX: begin
          r_hi     <= w_fix_hi;
          r_lo     <= w_fix_lo;
          r_result <= w_fix_lo;
          r_zero   <= (w_fix_lo == '0);
          r_div0   <= r_dz;
        end
        S_DONE: begin
          if (out_ready) begin
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_div0    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;
  assign div0    = r_div0;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised + directed self-checking bench for alu_exec_unit (WIDTH=32).
// The reference model computes each op with 64-bit arithmetic and tracks HI/LO.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    aluop = '0;
  logic [5:0]    func = '0;
  logic [4:0]    shamt = '0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;
  logic          div0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [8:0] op_tab [20];

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .func      (func),
    .shamt     (shamt),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .div0      (div0),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: result, flags and latency; updates m_hi/m_lo.
  task automatic model(input logic [2:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ill, output logic dz,
                       output int lat);
    longint      sa, sb;
    logic [63:0] t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0; ill = 1'b0; dz = 1'b0; lat = 1;
    case (aop)
      3'b001, 3'b010: res = a + b;
      3'b011:         res = a & b;
      3'b110:         res = a - b;
      3'b000: begin
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h10: res = m_hi;
          6'h12: res = m_lo;
          6'h18: begin t = sa * sb; m_hi = t[63:32]; m_lo = t[31:0]; res = m_lo; lat = W + 2; end
          6'h19: begin t = {32'd0, a} * {32'd0, b}; m_hi = t[63:32]; m_lo = t[31:0]; res = m_lo; lat = W + 2; end
          6'h1A, 6'h1B: begin
            if (b == 0) begin
              dz = 1'b1; m_lo = '1; m_hi = a; res = m_lo; lat = 2;
            end else if (fn == 6'h1A) begin
              t = sa / sb; m_lo = t[31:0];
              t = sa % sb; m_hi = t[31:0];
              res = m_lo; lat = W + 2;
            end else begin
              m_lo = a / b; m_hi = a % b; res = m_lo; lat = W + 2;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [2:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_res;
    logic        e_ill, e_dz;
    int          e_lat, lat;
    model(aop, fn, sh, a, b, e_res, e_ill, e_dz, e_lat);
    @(negedge clk);
    aluop = aop; func = fn; shamt = sh; src_a = a; src_b = b; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency a=%h f=%h", aop, fn), lat, e_lat);
    chk($sformatf("result a=%h f=%h %h %h", aop, fn, a, b), result, e_res);
    chk("zero", zero, (e_res == 0));
    chk("illegal", illegal, e_ill);
    chk("div0", div0, e_dz);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("flags_clear", {zero, illegal, div0}, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    int seen;
    op_tab = '{9'b001_111111, 9'b010_111111, 9'b011_111111, 9'b110_111111, 9'b111_100000,
               9'b000_100000, 9'b000_100010, 9'b000_100100, 9'b000_100101, 9'b000_100111,
               9'b000_101010, 9'b000_000000, 9'b000_000010, 9'b000_010000, 9'b000_010010,
               9'b000_011000, 9'b000_011001, 9'b000_011010, 9'b000_011011, 9'b000_111111};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, illegal, div0}, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // directed cases
    run_op(3'b000, 6'h22, 5'd0, 32'd5, 32'd5);
    run_op(3'b000, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    run_op(3'b000, 6'h10, 5'd0, 32'd0, 32'd0);
    chk("mfhi", result, 32'hFFFF_FFFF);
    run_op(3'b000, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'b000, 6'h1B, 5'd0, 32'd7, 32'd0);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);
    run_op(3'b000, 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'd0);
    run_op(3'b111, 6'h20, 5'd0, 32'd3, 32'd4);
    run_op(3'b000, 6'h3F, 5'd0, 32'd3, 32'd4);
    run_op(3'b000, 6'h00, 5'd31, 32'd0, 32'd1);
    chk("sll31", result, 32'h8000_0000);

    // backpressure on SLT -1 < 1
    @(negedge clk);
    out_ready = 1'b0;
    aluop = 3'b000; func = 6'h2A; src_a = '1; src_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("bp_hold", {out_valid, result}, {1'b1, 32'd1});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // reset in the middle of a MULTU
    @(negedge clk);
    aluop = 3'b000; func = 6'h19; src_a = 32'd12345; src_b = 32'd678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_hilo", {hi, lo}, 0);
    chk("mrst_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_result", seen, 0);

    // randomised ops
    for (int n = 0; n < 70; n++) begin
      logic [8:0] e;
      k = $urandom_range(0, 19);
      e = op_tab[k];
      run_op(e[8:6], e[5:0], 5'($urandom_range(0, 31)), pick(), pick());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
